fifo_stripe: RTL and testbench
==============================

FIFO_STRIPE -- requirements
Module: fifo_stripe

Interface
REQ-001 SHALL have parameter WIDTH, default 704, payload bits per element.
REQ-002 SHALL have parameter LANES, default 4, number of interleaved lane FIFOs; legal 2..16, power of two.
REQ-003 SHALL have parameter DEPTH, default 2, entries per lane FIFO; legal 1..16.
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 CLK  input  1  clock; all state updates on posedge CLK.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 in_enq__ENA  input  1  producer enqueue request.
REQ-008 in_enq_v  input  WIDTH  enqueue payload.
REQ-009 in_enq__RDY  output  1  enqueue accepted this cycle if ENA also high.
REQ-010 out_deq__ENA  input  1  consumer dequeue request.
REQ-011 out_deq__RDY  output  1  dequeue accepted this cycle if ENA also high.
REQ-012 out_first  output  WIDTH  head element.
REQ-013 out_first__RDY  output  1  out_first valid.
REQ-014 occupancy  output  clog2(LANES*DEPTH+1)  element count; present only per REQ-030.

Function
REQ-015 SHALL contain LANES independent FIFOs of DEPTH entries, total capacity LANES*DEPTH.
REQ-016 SHALL keep enq_ptr and deq_ptr, each clog2(LANES) bits, selecting the current write and read lane.
REQ-017 in_enq__RDY SHALL equal "lane[enq_ptr] not full", combinationally.
REQ-018 On in_enq__ENA && in_enq__RDY: write in_enq_v to tail of lane[enq_ptr]; enq_ptr <= enq_ptr+1 mod LANES.
REQ-019 out_first__RDY and out_deq__RDY SHALL both equal "lane[deq_ptr] not empty".
REQ-020 out_first SHALL be head of lane[deq_ptr] when out_first__RDY, else all zero.
REQ-021 On out_deq__ENA && out_deq__RDY: pop lane[deq_ptr]; deq_ptr <= deq_ptr+1 mod LANES.
REQ-022 ENA without RDY on either port SHALL be ignored: no state change, no pointer advance.
REQ-023 Output order SHALL equal input order exactly (strict round-robin on both sides, no lane skipping).
REQ-024 Latency: element enqueued in cycle N SHALL be visible at out_first no earlier than cycle N+1; no combinational in-to-out bypass.
REQ-025 Simultaneous enq and deq on the same lane SHALL both succeed when that lane is neither empty nor full; a full lane SHALL NOT accept enq even while dequeuing (RDY never depends on out_deq__ENA).
REQ-026 Pointer wrap LANES-1 -> 0 SHALL occur without bubble; lane internal pointers wrap DEPTH-1 -> 0 likewise.

Reset
REQ-027 While RST high at posedge CLK: enq_ptr=0, deq_ptr=0, all lanes empty, occupancy=0; stored data is don't-care.
REQ-028 Outputs after reset: in_enq__RDY=1, out_deq__RDY=0, out_first__RDY=0, out_first=0.
REQ-029 Reset asserted mid-operation SHALL discard all contents and override any concurrent enq/deq in that cycle.

Configuration
REQ-030 Macro FIFO_STRIPE_OCCUPANCY_EN defined: occupancy port exists, registered, +1 on accepted enq, -1 on accepted deq, unchanged on both or neither; never exceeds LANES*DEPTH.
REQ-031 Macro undefined: occupancy port and counter absent; all other behaviour identical.

Verification (WIDTH=8, LANES=4, DEPTH=2)
REQ-032 Reset, then enq 0x11,0x22,0x33,0x44 back-to-back, deq 4 -> out_first 0x11,0x22,0x33,0x44 in order; enq_ptr and deq_ptr both back to 0.
REQ-033 Enq 8 values 0x01..0x08 with no deq -> in_enq__RDY low on 9th cycle; occupancy=8; drain yields 0x01..0x08.
REQ-034 Enq 0xAA cycle 0 -> out_first__RDY low cycle 0, high cycle 1 with out_first=0xAA.
REQ-035 Steady stream: enq and deq asserted every cycle for 20 cycles after one preload -> no stalls, order preserved, occupancy constant at 1.
REQ-036 out_deq__ENA=1 while empty, and in_enq__ENA=1 while full -> no pointer or occupancy change.
REQ-037 Fill 5 entries, assert RST one cycle alongside enq/deq -> next cycle out_first__RDY=0, in_enq__RDY=1, occupancy=0.

Source files
------------

// File: rtl/fifo_stripe_if.sv
// fifo_stripe_if: enqueue/dequeue handshake bundle for fifo_stripe.
//   in_enq__ENA / in_enq_v / in_enq__RDY        producer side
//   out_deq__ENA / out_deq__RDY                 consumer pop handshake
//   out_first / out_first__RDY                  head element and its valid
// slave  : the FIFO itself.
// master : whoever drives requests (producer + consumer).
interface fifo_stripe_if #(
    parameter int WIDTH = 704
);
    logic             in_enq__ENA;
    logic [WIDTH-1:0] in_enq_v;
    logic             in_enq__RDY;
    logic             out_deq__ENA;
    logic             out_deq__RDY;
    logic [WIDTH-1:0] out_first;
    logic             out_first__RDY;

    modport slave (
        input  in_enq__ENA, in_enq_v, out_deq__ENA,
        output in_enq__RDY, out_deq__RDY, out_first, out_first__RDY
    );

    modport master (
        output in_enq__ENA, in_enq_v, out_deq__ENA,
        input  in_enq__RDY, out_deq__RDY, out_first, out_first__RDY
    );
endinterface

// File: rtl/fifo_stripe.sv
// fifo_stripe: LANES independent DEPTH-entry FIFOs striped round-robin.
// Writes go to lane[enq_ptr], reads come from lane[deq_ptr]; both pointers
// advance by one lane per accepted transfer, so ordering is preserved.
// Ports:
//   CLK, RST     clock, synchronous active-high reset
//   bus          fifo_stripe_if.slave handshake bundle
//   occupancy    element count (only with FIFO_STRIPE_OCCUPANCY_EN defined)
// Config macro: FIFO_STRIPE_OCCUPANCY_EN adds the registered occupancy counter.

// One lane: plain circular buffer. The caller only pushes when !full and
// pops when !empty.
module fifo_stripe_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wrap_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = wrap_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module fifo_stripe #(
    parameter int WIDTH = 704,
    parameter int LANES = 4,
    parameter int DEPTH = 2
) (
    input  logic CLK,
    input  logic RST,
`ifdef FIFO_STRIPE_OCCUPANCY_EN
    output logic [$clog2(LANES*DEPTH+1)-1:0] occupancy,
`endif
    fifo_stripe_if.slave bus
);
    localparam int LW = $clog2(LANES);

    logic [LW-1:0] enq_ptr_q, enq_ptr_d;
    logic [LW-1:0] deq_ptr_q, deq_ptr_d;

    logic [LANES-1:0]            lane_push, lane_pop, lane_empty, lane_full;
    logic [LANES-1:0][WIDTH-1:0] lane_dout;

    logic enq_rdy, deq_rdy, enq_fire, deq_fire;

    // Readiness looks only at the selected lane's state, never at the
    // opposite port, so a full lane refuses enq even during a deq.
    assign enq_rdy  = !lane_full[enq_ptr_q];
    assign deq_rdy  = !lane_empty[deq_ptr_q];
    assign enq_fire = bus.in_enq__ENA && enq_rdy;
    assign deq_fire = bus.out_deq__ENA && deq_rdy;

    assign bus.in_enq__RDY    = enq_rdy;
    assign bus.out_deq__RDY   = deq_rdy;
    assign bus.out_first__RDY = deq_rdy;
    assign bus.out_first      = deq_rdy ? lane_dout[deq_ptr_q] : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_push[i] = enq_fire && (enq_ptr_q == LW'(i));
        assign lane_pop[i]  = deq_fire && (deq_ptr_q == LW'(i));

        fifo_stripe_lane #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_lane (
            .clk   (CLK),
            .rst   (RST),
            .push  (lane_push[i]),
            .pop   (lane_pop[i]),
            .din   (bus.in_enq_v),
            .dout  (lane_dout[i]),
            .empty (lane_empty[i]),
            .full  (lane_full[i])
        );
    end

    // LANES is a power of two, so the lane pointers wrap naturally.
    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        if (enq_fire) enq_ptr_d = enq_ptr_q + LW'(1);
        if (deq_fire) deq_ptr_d = deq_ptr_q + LW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
        end
    end

`ifdef FIFO_STRIPE_OCCUPANCY_EN
    localparam int OW = $clog2(LANES*DEPTH+1);

    logic [OW-1:0] occ_q, occ_d;

    // Accepted enq only fires on a non-full lane, so the count is bounded
    // by LANES*DEPTH without an explicit saturation check.
    always_comb begin
        occ_d = occ_q;
        case ({enq_fire, deq_fire})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) occ_q <= '0;
        else     occ_q <= occ_d;
    end

    assign occupancy = occ_q;
`endif
endmodule

// File: tb/tb_fifo_stripe.sv
module tb_fifo_stripe;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    fifo_stripe_if #(.WIDTH(8)) bus ();

`ifdef FIFO_STRIPE_OCCUPANCY_EN
    logic [3:0] occupancy;
    fifo_stripe #(.WIDTH(8), .LANES(4), .DEPTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .occupancy (occupancy),
        .bus       (bus.slave)
    );
`else
    fifo_stripe #(.WIDTH(8), .LANES(4), .DEPTH(2)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted dequeue must present the oldest
    // expected element.
    always @(negedge CLK) begin
        if (!RST && bus.out_deq__ENA && bus.out_deq__RDY) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL deq_unexpected: got %0h expected nothing", bus.out_first);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("deq_data", 32'(bus.out_first), 32'(mon_exp));
            end
        end
    end

    // One cycle of stimulus; er/dr are the hand-computed ready levels.
    task automatic do_cycle(input logic e, input logic [7:0] v, input logic d,
                            input logic er, input logic dr, input string nm);
        bus.in_enq__ENA  = e;
        bus.in_enq_v     = v;
        bus.out_deq__ENA = d;
        if (e && er) exp_q.push_back(v);
        @(negedge CLK);
        chk({nm, "_enq_rdy"}, 32'(bus.in_enq__RDY), 32'(er));
        chk({nm, "_deq_rdy"}, 32'(bus.out_deq__RDY), 32'(dr));
        chk({nm, "_first_rdy"}, 32'(bus.out_first__RDY), 32'(dr));
        if (!dr) chk({nm, "_first_zero"}, 32'(bus.out_first), 32'h0);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_enq__ENA  = 1'b0;
        bus.in_enq_v     = 8'h00;
        bus.out_deq__ENA = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
    endtask

    task automatic chk_occ(input string nm, input int exp);
`ifdef FIFO_STRIPE_OCCUPANCY_EN
        chk(nm, 32'(occupancy), 32'(exp));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_enq_rdy", 32'(bus.in_enq__RDY), 32'h1);
        chk("rst_deq_rdy", 32'(bus.out_deq__RDY), 32'h0);
        chk("rst_first_rdy", 32'(bus.out_first__RDY), 32'h0);
        chk("rst_first", 32'(bus.out_first), 32'h0);
        chk_occ("rst_occ", 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Four back-to-back enqs, one per lane, then drain in order.
        do_cycle(1'b1, 8'h11, 1'b0, 1'b1, 1'b0, "t1_e0");
        do_cycle(1'b1, 8'h22, 1'b0, 1'b1, 1'b1, "t1_e1");
        do_cycle(1'b1, 8'h33, 1'b0, 1'b1, 1'b1, "t1_e2");
        do_cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, "t1_e3");
        for (int i = 0; i < 4; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "t1_d");
        chk("t1_enq_ptr", 32'(dut.enq_ptr_q), 32'h0);
        chk("t1_deq_ptr", 32'(dut.deq_ptr_q), 32'h0);

        // Enqueued element becomes visible one cycle later, not the same cycle.
        apply_reset();
        do_cycle(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, "t2_e");
        idle_inputs();
        @(negedge CLK);
        chk("t2_first_rdy", 32'(bus.out_first__RDY), 32'h1);
        chk("t2_first", 32'(bus.out_first), 32'hAA);
        @(posedge CLK);
        #1;
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "t2_d");

        // Fill all 8 entries, 9th enq refused, then drain; deq on empty ignored.
        apply_reset();
        for (int i = 1; i <= 8; i++)
            do_cycle(1'b1, 8'(i), 1'b0, 1'b1, (i > 1), "t3_e");
        do_cycle(1'b1, 8'h09, 1'b0, 1'b0, 1'b1, "t3_full");
        chk_occ("t3_occ_full", 8);
        chk("t3_enq_ptr_full", 32'(dut.enq_ptr_q), 32'h0);
        for (int i = 0; i < 8; i++)
            do_cycle(1'b0, 8'h00, 1'b1, (i > 0), 1'b1, "t3_d");
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, "t3_empty");
        chk("t3_deq_ptr_empty", 32'(dut.deq_ptr_q), 32'h0);
        chk_occ("t3_occ_empty", 0);

        // Steady stream: one preload then enq+deq every cycle.
        apply_reset();
        do_cycle(1'b1, 8'h50, 1'b0, 1'b1, 1'b0, "t4_pre");
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b1, 1'b1, "t4_s");
            chk_occ("t4_occ", 1);
        end
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "t4_drain");

        // Reset mid-operation overrides concurrent enq/deq.
        apply_reset();
        for (int i = 0; i < 5; i++)
            do_cycle(1'b1, 8'(8'h81 + i), 1'b0, 1'b1, (i > 0), "t5_e");
        chk_occ("t5_occ_pre", 5);
        RST              = 1'b1;
        bus.in_enq__ENA  = 1'b1;
        bus.in_enq_v     = 8'h86;
        bus.out_deq__ENA = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle_inputs();
        exp_q.delete();
        @(negedge CLK);
        chk("t5_enq_rdy", 32'(bus.in_enq__RDY), 32'h1);
        chk("t5_first_rdy", 32'(bus.out_first__RDY), 32'h0);
        chk("t5_first", 32'(bus.out_first), 32'h0);
        chk_occ("t5_occ", 0);
        @(posedge CLK);
        #1;
        do_cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, "t5_post_e");
        do_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, "t5_post_d");
        idle_inputs();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
